simon_96144_host: RTL and testbench

SIMON_96144_HOST -- requirements
Module: simon_96144_host

---
 rtl/simon_96144_host.sv | 235 +++++++++++++++++++++++
 tb/tb_simon_96144_host.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simon_96144_host.sv
// Host-side wrapper for a SIMON 96/144 core: collects key/block beats from a
// narrow bus, hands them to the core, and streams the result back out.
module simon_96144_host #(
  parameter int N  = 48,
  parameter int M  = 3,
  parameter int W  = 16,
  parameter int TO = 255
) (
  input  logic             clk,
  input  logic             nR,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_key,
  input  logic             cmd_enc,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic             busy,
  output logic             err,
  output logic             newKey,
  output logic             newData,
  output logic             enc_dec,
  output logic             readData,
  output logic [M*N-1:0]   KEY,
  output logic [2*N-1:0]   BLOCK,
  input  logic             loadKey,
  input  logic             loadData,
  input  logic             doneKey,
  input  logic             doneData,
  input  logic [2*N-1:0]   outData,
  input  logic [3:0]       mode
);

  localparam int KB  = (M * N) / W;
  localparam int DB  = (2 * N) / W;
  localparam int KIW = (KB > 1) ? $clog2(KB) : 1;
  localparam int DIW = (DB > 1) ? $clog2(DB) : 1;
  localparam int WDW = (TO > 1) ? $clog2(TO) : 1;
  localparam logic [3:0]     KEY_LAST  = 4'(KB - 1);
  localparam logic [3:0]     DATA_LAST = 4'(DB - 1);
  localparam logic [WDW-1:0] WD_LAST   = WDW'(TO - 1);

  typedef enum logic [2:0] {
    IDLE, COLLECT, WAIT_LOAD, ISSUE, WAIT_DONE, ACK, EMIT
  } state_t;

  state_t           state_reg;
  logic             key_cmd_reg;
  logic             enc_reg;
  logic             key_loaded_reg;
  logic [3:0]       beat_reg;
  logic [WDW-1:0]   wd_reg;
  logic             cmd_ready_reg;
  logic             in_ready_reg;
  logic             out_valid_reg;
  logic             busy_reg;
  logic             err_reg;
  logic             new_key_reg;
  logic             new_data_reg;
  logic             read_data_reg;
  logic [2*N-1:0]   result_reg;
  logic [W-1:0]     key_words_reg   [KB];
  logic [W-1:0]     block_words_reg [DB];
  logic [W-1:0]     res_words       [DB];

  logic             load_ok;
  logic             wd_expired;
  logic             beat_write;
  logic [3:0]       last_beat;
  logic             unused_mode;

  assign load_ok     = key_cmd_reg ? loadKey : loadData;
  assign wd_expired  = (wd_reg == WD_LAST);
  assign beat_write  = (state_reg == COLLECT) && in_valid;
  assign last_beat   = key_cmd_reg ? KEY_LAST : DATA_LAST;
  assign unused_mode = ^mode;

  always_ff @(posedge clk) begin
    if (!nR) begin
      state_reg      <= IDLE;
      key_cmd_reg    <= 1'b0;
      enc_reg        <= 1'b0;
      key_loaded_reg <= 1'b0;
      beat_reg       <= '0;
      wd_reg         <= '0;
      cmd_ready_reg  <= 1'b1;
      in_ready_reg   <= 1'b0;
      out_valid_reg  <= 1'b0;
      busy_reg       <= 1'b0;
      err_reg        <= 1'b0;
      new_key_reg    <= 1'b0;
      new_data_reg   <= 1'b0;
      read_data_reg  <= 1'b0;
      result_reg     <= '0;
    end else begin
      err_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (cmd_valid && cmd_ready_reg) begin
            key_cmd_reg <= cmd_key;
            enc_reg     <= cmd_enc;
            beat_reg    <= '0;
            if (cmd_key) key_loaded_reg <= 1'b0;
            // A data command needs a key already expanded inside the core.
            if (!cmd_key && !key_loaded_reg) begin
              err_reg <= 1'b1;
            end else begin
              state_reg     <= COLLECT;
              cmd_ready_reg <= 1'b0;
              in_ready_reg  <= 1'b1;
              busy_reg      <= 1'b1;
            end
          end
        end
        COLLECT: begin
          if (in_valid) begin
            beat_reg <= beat_reg + 4'd1;
            if (beat_reg == last_beat) begin
              state_reg    <= WAIT_LOAD;
              in_ready_reg <= 1'b0;
              wd_reg       <= '0;
            end
          end
        end
        WAIT_LOAD: begin
          if (load_ok) begin
            state_reg <= ISSUE;
            if (key_cmd_reg) new_key_reg  <= 1'b1;
            else             new_data_reg <= 1'b1;
          end else if (wd_expired) begin
            err_reg        <= 1'b1;
            key_loaded_reg <= 1'b0;
            state_reg      <= IDLE;
            cmd_ready_reg  <= 1'b1;
            busy_reg       <= 1'b0;
          end else begin
            wd_reg <= wd_reg + 1'b1;
          end
        end
        ISSUE: begin
          new_key_reg  <= 1'b0;
          new_data_reg <= 1'b0;
          state_reg    <= WAIT_DONE;
          wd_reg       <= '0;
        end
        WAIT_DONE: begin
          // Only the completion matching the issued operation is honoured.
          if (key_cmd_reg && doneKey) begin
            key_loaded_reg <= 1'b1;
            state_reg      <= IDLE;
            cmd_ready_reg  <= 1'b1;
            busy_reg       <= 1'b0;
          end else if (!key_cmd_reg && doneData) begin
            result_reg    <= outData;
            state_reg     <= ACK;
            read_data_reg <= 1'b1;
          end else if (wd_expired) begin
            err_reg        <= 1'b1;
            key_loaded_reg <= 1'b0;
            state_reg      <= IDLE;
            cmd_ready_reg  <= 1'b1;
            busy_reg       <= 1'b0;
          end else begin
            wd_reg <= wd_reg + 1'b1;
          end
        end
        ACK: begin
          read_data_reg <= 1'b0;
          state_reg     <= EMIT;
          beat_reg      <= '0;
          out_valid_reg <= 1'b1;
        end
        EMIT: begin
          if (out_ready) begin
            beat_reg <= beat_reg + 4'd1;
            if (beat_reg == DATA_LAST) begin
              out_valid_reg <= 1'b0;
              state_reg     <= IDLE;
              cmd_ready_reg <= 1'b1;
              busy_reg      <= 1'b0;
            end
          end
        end
        default: begin
          state_reg     <= IDLE;
          cmd_ready_reg <= 1'b1;
          in_ready_reg  <= 1'b0;
          out_valid_reg <= 1'b0;
          busy_reg      <= 1'b0;
          new_key_reg   <= 1'b0;
          new_data_reg  <= 1'b0;
          read_data_reg <= 1'b0;
        end
      endcase
    end
  end

  // Operand words only change in COLLECT, so KEY/BLOCK stay frozen while
  // the core owns them.
  always_ff @(posedge clk) begin
    if (!nR) begin
      for (int i = 0; i < KB; i++) key_words_reg[i] <= '0;
      for (int i = 0; i < DB; i++) block_words_reg[i] <= '0;
    end else if (beat_write) begin
      if (key_cmd_reg) key_words_reg[beat_reg[KIW-1:0]]   <= in_data;
      else             block_words_reg[beat_reg[DIW-1:0]] <= in_data;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < KB; gi++) begin : g_key
      assign KEY[gi*W +: W] = key_words_reg[gi];
    end
    for (gi = 0; gi < DB; gi++) begin : g_blk
      assign BLOCK[gi*W +: W] = block_words_reg[gi];
      assign res_words[gi]    = result_reg[gi*W +: W];
    end
  endgenerate

  assign out_data  = out_valid_reg ? res_words[beat_reg[DIW-1:0]] : '0;
  assign cmd_ready = cmd_ready_reg;
  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign busy      = busy_reg;
  assign err       = err_reg;
  assign newKey    = new_key_reg;
  assign newData   = new_data_reg;
  assign readData  = read_data_reg;
  assign enc_dec   = enc_reg;

endmodule

// File: tb/tb_simon_96144_host.sv
// Directed bench for simon_96144_host with a behavioural stub of the SIMON core.
module tb_simon_96144_host;
  localparam int N  = 48;
  localparam int M  = 3;
  localparam int W  = 16;
  localparam int TO = 255;

  logic           clk = 1'b0;
  logic           nR = 1'b0;
  logic           cmd_valid = 1'b0, cmd_key = 1'b0, cmd_enc = 1'b0;
  logic           cmd_ready;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   in_data = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [W-1:0]   out_data;
  logic           busy, err, newKey, newData, enc_dec, readData;
  logic [M*N-1:0] KEY;
  logic [2*N-1:0] BLOCK;
  logic           loadKey = 1'b1, loadData = 1'b1;
  logic           doneKey = 1'b0, doneData = 1'b0;
  logic [2*N-1:0] outData = '0;
  logic [3:0]     mode = 4'h0;

  always #5 clk = ~clk;

  simon_96144_host #(.N(N), .M(M), .W(W), .TO(TO)) dut (
    .clk(clk), .nR(nR),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_key(cmd_key), .cmd_enc(cmd_enc),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .err(err), .newKey(newKey), .newData(newData),
    .enc_dec(enc_dec), .readData(readData), .KEY(KEY), .BLOCK(BLOCK),
    .loadKey(loadKey), .loadData(loadData), .doneKey(doneKey), .doneData(doneData),
    .outData(outData), .mode(mode)
  );

  int vectors = 0;
  int miscompares = 0;

  // Core stub: doneKey 60 cycles after newKey, doneData 5 cycles after newData.
  int             cyc = 0, key_timer = 0, data_timer = 0;
  bit             stub_data_en = 1'b1;
  int             newkey_cnt = 0, newdata_cnt = 0, readdata_cnt = 0, err_cnt = 0;
  int             newdata_cyc = 0, err_cyc = 0;
  logic [M*N-1:0] key_at_new = '0;
  logic [2*N-1:0] block_at_new = '0;
  logic           enc_at_new = 1'b0;

  always @(negedge clk) begin
    cyc++;
    doneKey  = 1'b0;
    doneData = 1'b0;
    if (key_timer > 0) begin key_timer--; if (key_timer == 0) doneKey = 1'b1; end
    if (data_timer > 0) begin data_timer--; if (data_timer == 0) doneData = 1'b1; end
    if (newKey) begin newkey_cnt++; key_at_new = KEY; key_timer = 60; end
    if (newData) begin
      newdata_cnt++; newdata_cyc = cyc; block_at_new = BLOCK; enc_at_new = enc_dec;
      if (stub_data_en) data_timer = 5;
    end
    if (readData) readdata_cnt++;
    if (err) begin err_cnt++; err_cyc = cyc; end
  end

  logic [W-1:0] beat_buf [16];
  logic [W-1:0] rx_buf   [16];
  logic [W-1:0] exp_buf  [16];
  int           rx_n;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_cmd(input logic key, input logic enc);
    int n = 0;
    cmd_key = key; cmd_enc = enc; cmd_valid = 1'b1;
    while (!cmd_ready && n < 50) begin tick(); n++; end
    if (!cmd_ready) begin
      vectors++; miscompares++;
      $display("FAIL cmd_accept: cmd_ready=%0b required 1 within 50 cycles", cmd_ready);
    end
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic send_beats(input int cnt, input int gap);
    for (int i = 0; i < cnt; i++) begin
      int n = 0;
      in_data = beat_buf[i]; in_valid = 1'b1;
      while (!in_ready && n < 50) begin tick(); n++; end
      if (!in_ready) begin
        vectors++; miscompares++;
        $display("FAIL in_accept beat %0d: in_ready=%0b required 1", i, in_ready);
      end
      tick();
      in_valid = 1'b0; in_data = 16'hDEAD;
      repeat (gap) tick();
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin tick(); n++; end
    if (busy) begin
      vectors++; miscompares++;
      $display("FAIL wait_idle: busy=%0b required 0 within %0d cycles", busy, budget);
    end
  endtask

  task automatic recv_beats(input int cnt, input bit toggle);
    int n = 0;
    bit held_flag = 1'b0;
    logic [W-1:0] held = '0;
    rx_n = 0;
    out_ready = toggle ? 1'b0 : 1'b1;
    while (rx_n < cnt && n < 300) begin
      if (held_flag && out_valid) begin
        vectors++;
        if (out_data !== held) begin
          miscompares++;
          $display("FAIL out_hold: out_data=%h required %h", out_data, held);
        end
      end
      held_flag = 1'b0;
      if (out_valid && out_ready) begin
        rx_buf[rx_n] = out_data; rx_n++;
      end else if (out_valid) begin
        held = out_data; held_flag = 1'b1;
      end
      tick(); n++;
      if (toggle) out_ready = ~out_ready;
    end
    out_ready = 1'b0;
    vectors++;
    if (rx_n !== cnt) begin
      miscompares++;
      $display("FAIL recv_count: got %0d beats required %0d", rx_n, cnt);
    end
    for (int i = 0; i < rx_n; i++) begin
      vectors++;
      if (rx_buf[i] !== exp_buf[i]) begin
        miscompares++;
        $display("FAIL out_beat %0d: out_data=%h required %h", i, rx_buf[i], exp_buf[i]);
      end
    end
  endtask

  task automatic test_reset();
    nR = 1'b0;
    repeat (3) tick();
    vectors++;
    if ({cmd_ready, busy, in_ready, out_valid, err, newKey, newData, readData, enc_dec} !== 9'b1_0000_0000) begin
      miscompares++;
      $display("FAIL reset_ctrl: {cmd_ready,busy,in_ready,out_valid,err,newKey,newData,readData,enc_dec}=%b required 100000000",
               {cmd_ready, busy, in_ready, out_valid, err, newKey, newData, readData, enc_dec});
    end
    vectors++;
    if (KEY !== '0) begin miscompares++; $display("FAIL reset_key: KEY=%h required 0", KEY); end
    vectors++;
    if (BLOCK !== '0) begin miscompares++; $display("FAIL reset_block: BLOCK=%h required 0", BLOCK); end
    vectors++;
    if (out_data !== '0) begin miscompares++; $display("FAIL reset_out_data: out_data=%h required 0", out_data); end
    nR = 1'b1;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_data_no_key();
    int e0 = err_cnt;
    send_cmd(1'b0, 1'b1);
    vectors++;
    if ({err, busy, in_ready} !== 3'b100) begin
      miscompares++;
      $display("FAIL nokey_err: {err,busy,in_ready}=%b required 100", {err, busy, in_ready});
    end
    tick();
    vectors++;
    if ({err, busy, in_ready, cmd_ready} !== 4'b0001) begin
      miscompares++;
      $display("FAIL nokey_after: {err,busy,in_ready,cmd_ready}=%b required 0001", {err, busy, in_ready, cmd_ready});
    end
    tick();
    vectors++;
    if (err_cnt - e0 !== 1) begin
      miscompares++;
      $display("FAIL nokey_pulse: err high %0d cycles required 1", err_cnt - e0);
    end
    $display("test_data_no_key done");
  endtask

  task automatic test_key_load();
    logic [M*N-1:0] kexp = 144'h1110_0F0E_0D0C_0B0A_0908_0706_0504_0302_0100;
    int nk0 = newkey_cnt;
    for (int i = 0; i < 9; i++) beat_buf[i] = {8'(2*i + 1), 8'(2*i)};
    send_cmd(1'b1, 1'b0);
    send_beats(9, 0);
    wait_idle(150);
    vectors++;
    if (newkey_cnt - nk0 !== 1) begin
      miscompares++;
      $display("FAIL key_newkey: newKey high %0d cycles required 1", newkey_cnt - nk0);
    end
    vectors++;
    if (key_at_new !== kexp) begin
      miscompares++;
      $display("FAIL key_at_newkey: KEY=%h required %h", key_at_new, kexp);
    end
    vectors++;
    if (KEY !== kexp) begin miscompares++; $display("FAIL key_hold: KEY=%h required %h", KEY, kexp); end
    vectors++;
    if (dut.key_loaded_reg !== 1'b1) begin
      miscompares++;
      $display("FAIL key_loaded: key_loaded=%0b required 1", dut.key_loaded_reg);
    end
    $display("test_key_load done");
  endtask

  task automatic test_encrypt();
    int rd0 = readdata_cnt;
    int nd0 = newdata_cnt;
    outData = 96'h1234_5678_9ABC_DEF0_1234_5678;
    for (int i = 0; i < 6; i++) beat_buf[i] = 16'hAAAA;
    exp_buf[0] = 16'h5678; exp_buf[1] = 16'h1234; exp_buf[2] = 16'hDEF0;
    exp_buf[3] = 16'h9ABC; exp_buf[4] = 16'h5678; exp_buf[5] = 16'h1234;
    send_cmd(1'b0, 1'b1);
    send_beats(6, 2);
    recv_beats(6, 1'b0);
    vectors++;
    if ({out_valid, busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL enc_end: {out_valid,busy}=%b required 00", {out_valid, busy});
    end
    vectors++;
    if (readdata_cnt - rd0 !== 1) begin
      miscompares++;
      $display("FAIL enc_readdata: readData high %0d cycles required 1", readdata_cnt - rd0);
    end
    vectors++;
    if (newdata_cnt - nd0 !== 1) begin
      miscompares++;
      $display("FAIL enc_newdata: newData high %0d cycles required 1", newdata_cnt - nd0);
    end
    vectors++;
    if (block_at_new !== {6{16'hAAAA}} || enc_at_new !== 1'b1) begin
      miscompares++;
      $display("FAIL enc_operands: BLOCK=%h enc_dec=%0b required %h 1", block_at_new, enc_at_new, {6{16'hAAAA}});
    end
    $display("test_encrypt done");
  endtask

  task automatic test_backpressure();
    logic [2*N-1:0] bexp;
    outData = 96'hFEDC_BA98_7654_3210_0F1E_2D3C;
    for (int i = 0; i < 6; i++) begin
      beat_buf[i] = 16'h1000 + 16'(i);
      bexp[i*W +: W] = 16'h1000 + 16'(i);
    end
    exp_buf[0] = 16'h2D3C; exp_buf[1] = 16'h0F1E; exp_buf[2] = 16'h3210;
    exp_buf[3] = 16'h7654; exp_buf[4] = 16'hBA98; exp_buf[5] = 16'hFEDC;
    send_cmd(1'b0, 1'b0);
    send_beats(6, 1);
    recv_beats(6, 1'b1);
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_no_extra: out_valid=%0b required 0", out_valid);
    end
    vectors++;
    if (block_at_new !== bexp || enc_at_new !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_operands: BLOCK=%h enc_dec=%0b required %h 0", block_at_new, enc_at_new, bexp);
    end
    $display("test_backpressure done");
  endtask

  task automatic test_watchdog();
    int e0 = err_cnt;
    int rd0 = readdata_cnt;
    int e1;
    stub_data_en = 1'b0;
    for (int i = 0; i < 6; i++) beat_buf[i] = 16'h5A5A;
    send_cmd(1'b0, 1'b1);
    send_beats(6, 0);
    wait_idle(TO + 60);
    tick();
    vectors++;
    if (err_cyc - newdata_cyc !== TO + 1) begin
      miscompares++;
      $display("FAIL wd_latency: err %0d cycles after newData required %0d", err_cyc - newdata_cyc, TO + 1);
    end
    vectors++;
    if (err_cnt - e0 !== 1) begin
      miscompares++;
      $display("FAIL wd_pulse: err high %0d cycles required 1", err_cnt - e0);
    end
    vectors++;
    if (readdata_cnt - rd0 !== 0) begin
      miscompares++;
      $display("FAIL wd_readdata: readData high %0d cycles required 0", readdata_cnt - rd0);
    end
    vectors++;
    if (dut.key_loaded_reg !== 1'b0) begin
      miscompares++;
      $display("FAIL wd_key_cleared: key_loaded=%0b required 0", dut.key_loaded_reg);
    end
    stub_data_en = 1'b1;
    e1 = err_cnt;
    send_cmd(1'b0, 1'b1);
    vectors++;
    if ({err, in_ready} !== 2'b10) begin
      miscompares++;
      $display("FAIL wd_then_nokey: {err,in_ready}=%b required 10 (e1=%0d)", {err, in_ready}, e1);
    end
    tick();
    $display("test_watchdog done");
  endtask

  task automatic test_reset_mid();
    logic [M*N-1:0] kexp;
    int nk0;
    for (int i = 0; i < 9; i++) begin
      beat_buf[i] = 16'hA000 + 16'(i);
      kexp[i*W +: W] = 16'hA000 + 16'(i);
    end
    send_cmd(1'b1, 1'b0);
    send_beats(2, 0);
    in_data = beat_buf[2]; in_valid = 1'b1; nR = 1'b0;
    tick();
    vectors++;
    if ({cmd_ready, busy, in_ready, out_valid, err, newKey, newData, readData, enc_dec} !== 9'b1_0000_0000) begin
      miscompares++;
      $display("FAIL midreset_ctrl: outputs=%b required 100000000",
               {cmd_ready, busy, in_ready, out_valid, err, newKey, newData, readData, enc_dec});
    end
    vectors++;
    if (KEY !== '0) begin miscompares++; $display("FAIL midreset_key: KEY=%h required 0", KEY); end
    nR = 1'b1; in_valid = 1'b0;
    tick();
    vectors++;
    if ({newKey, newData, readData, busy} !== 4'b0000) begin
      miscompares++;
      $display("FAIL midreset_after: {newKey,newData,readData,busy}=%b required 0000", {newKey, newData, readData, busy});
    end
    nk0 = newkey_cnt;
    send_cmd(1'b1, 1'b0);
    send_beats(9, 1);
    wait_idle(150);
    vectors++;
    if (newkey_cnt - nk0 !== 1 || key_at_new !== kexp) begin
      miscompares++;
      $display("FAIL midreset_reload: newKey cycles=%0d KEY=%h required 1 %h", newkey_cnt - nk0, key_at_new, kexp);
    end
    vectors++;
    if (dut.key_loaded_reg !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset_key_loaded: key_loaded=%0b required 1", dut.key_loaded_reg);
    end
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_data_no_key();
    test_key_load();
    test_encrypt();
    test_backpressure();
    test_watchdog();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
